// File: rtl/pipeline_writeback.sv
// Writeback stage: owns the integer register file, sequences environment
// calls through an external handler, and counts retired instructions.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | accepting writeback bundles (ready = 1)
// ECALL_REQ  | ECALL_VALID asserted with a0..a7 snapshot, awaiting ECALL_READY
// ECALL_WAIT | request accepted, awaiting ECALL_DONE to write a0
module pipeline_writeback #(
   parameter int                    DATA_WIDTH = 64,
   parameter logic [DATA_WIDTH-1:0] STACK_TOP  = '0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wb_enable,
   input  logic [4:0]              wb_dst_reg,
   input  logic [DATA_WIDTH-1:0]   wb_dst_val,
   input  logic                    ecall_wb,
   output logic                    ready,
   input  logic [4:0]              rs1_addr,
   input  logic [4:0]              rs2_addr,
   output logic [DATA_WIDTH-1:0]   rs1_val,
   output logic [DATA_WIDTH-1:0]   rs2_val,
   output logic                    ECALL_VALID,
   output logic [8*DATA_WIDTH-1:0] ECALL_ARGS,
   input  logic                    ECALL_READY,
   input  logic                    ECALL_DONE,
   input  logic [DATA_WIDTH-1:0]   ECALL_RET,
   output logic [63:0]             INSTRET
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      ECALL_REQ  = 2'd1,
      ECALL_WAIT = 2'd2
   } state_t;

   localparam logic [4:0] REG_A0 = 5'd10;

   state_t                  state;
   state_t                  state_next;
   logic [DATA_WIDTH-1:0]   regs [32];
   logic                    wr_en;
   logic                    wr_commit;
   logic [4:0]              wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic                    retire;
   logic                    take_ecall;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state, handshake outputs and the single register-file write port
   always_comb begin
      state_next  = state;
      wr_en       = 1'b0;
      wr_addr     = wb_dst_reg;
      wr_data     = wb_dst_val;
      retire      = 1'b0;
      take_ecall  = 1'b0;
      ready       = (state == IDLE);
      ECALL_VALID = (state == ECALL_REQ) && !reset;
      unique case (state)
         IDLE: begin
            if (ecall_wb) begin
               take_ecall = 1'b1;
               retire     = 1'b1;
               state_next = ECALL_REQ;
            end else if (wb_enable) begin
               wr_en  = 1'b1;
               retire = 1'b1;
            end
         end
         ECALL_REQ: begin
            if (ECALL_READY) state_next = ECALL_WAIT;
         end
         ECALL_WAIT: begin
            if (ECALL_DONE) begin
               wr_en      = 1'b1;
               wr_addr    = REG_A0;
               wr_data    = ECALL_RET;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A write only lands if reset is not also asserted on that edge; x0 is never stored
   assign wr_commit = wr_en && !reset && (wr_addr != 5'd0);

   // Register file with x2 preset to the stack top
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= (i == 2) ? STACK_TOP : '0;
         end
      end else if (wr_commit) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Snapshot of a0..a7 taken as the ecall retires, held through the handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         ECALL_ARGS <= '0;
      end else if (take_ecall) begin
         for (int k = 0; k < 8; k++) begin
            ECALL_ARGS[k*DATA_WIDTH +: DATA_WIDTH] <= regs[10+k];
         end
      end
   end

   // Retired-instruction counter; ecall completion does not retire again
   always_ff @(posedge clk) begin
      if (reset)       INSTRET <= '0;
      else if (retire) INSTRET <= INSTRET + 64'd1;
   end

   // Read ports with same-cycle bypass of the committing write
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (rs1_addr != 5'd0) begin
         if (wr_commit && (wr_addr == rs1_addr)) rs1_val = wr_data;
         else                                    rs1_val = regs[rs1_addr];
      end
      if (rs2_addr != 5'd0) begin
         if (wr_commit && (wr_addr == rs2_addr)) rs2_val = wr_data;
         else                                    rs2_val = regs[rs2_addr];
      end
   end

endmodule

// File: tb/tb_pipeline_writeback.sv
module tb_pipeline_writeback;

   localparam int DW = 64;

   logic          clk;
   logic          reset;
   logic          wb_enable;
   logic [4:0]    wb_dst_reg;
   logic [DW-1:0] wb_dst_val;
   logic          ecall_wb;
   logic          ready;
   logic [4:0]    rs1_addr;
   logic [4:0]    rs2_addr;
   logic [DW-1:0] rs1_val;
   logic [DW-1:0] rs2_val;
   logic          ECALL_VALID;
   logic [8*DW-1:0] ECALL_ARGS;
   logic          ECALL_READY;
   logic          ECALL_DONE;
   logic [DW-1:0] ECALL_RET;
   logic [63:0]   INSTRET;

   int checks   = 0;
   int failures = 0;

   pipeline_writeback #(.DATA_WIDTH(DW), .STACK_TOP(64'h8000)) dut (
      .clk(clk), .reset(reset),
      .wb_enable(wb_enable), .wb_dst_reg(wb_dst_reg), .wb_dst_val(wb_dst_val),
      .ecall_wb(ecall_wb), .ready(ready),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .ECALL_VALID(ECALL_VALID), .ECALL_ARGS(ECALL_ARGS),
      .ECALL_READY(ECALL_READY), .ECALL_DONE(ECALL_DONE), .ECALL_RET(ECALL_RET),
      .INSTRET(INSTRET)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          we;
      logic [4:0]    dst;
      logic [DW-1:0] val;
      logic [4:0]    rs1;
      logic [4:0]    rs2;
      logic [DW-1:0] exp1;
      logic [DW-1:0] exp2;
      logic [63:0]   exp_instret;
   } vec_t;

   typedef struct {
      logic [4:0]    addr;
      logic [DW-1:0] val;
   } sb_t;

   vec_t vecs [7];
   sb_t  sb_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic read_reg(input logic [4:0] a, input logic [DW-1:0] exp, input string name);
      @(negedge clk);
      rs1_addr = a;
      #1;
      check(name, rs1_val, exp);
   endtask

   logic [DW-1:0] args_a0_hold;
   logic [DW-1:0] args_a7_hold;
   sb_t           e;

   initial begin
      vecs[0] = '{1'b1, 5'd7,  64'hDEAD_BEEF,          5'd7,  5'd2,  64'hDEAD_BEEF,          64'h8000,               64'd1};
      vecs[1] = '{1'b0, 5'd7,  64'h0,                  5'd7,  5'd5,  64'hDEAD_BEEF,          64'h0,                  64'd1};
      vecs[2] = '{1'b1, 5'd0,  64'h5,                  5'd0,  5'd7,  64'h0,                  64'hDEAD_BEEF,          64'd2};
      vecs[3] = '{1'b1, 5'd10, 64'h1,                  5'd10, 5'd7,  64'h1,                  64'hDEAD_BEEF,          64'd3};
      vecs[4] = '{1'b1, 5'd17, 64'd93,                 5'd17, 5'd10, 64'd93,                 64'h1,                  64'd4};
      vecs[5] = '{1'b1, 5'd3,  64'h0123_4567_89AB_CDEF, 5'd3, 5'd3,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'd5};
      vecs[6] = '{1'b0, 5'd3,  64'hFFFF,               5'd3,  5'd17, 64'h0123_4567_89AB_CDEF, 64'd93,                 64'd5};

      reset = 1'b1; wb_enable = 1'b0; wb_dst_reg = '0; wb_dst_val = '0; ecall_wb = 1'b0;
      rs1_addr = '0; rs2_addr = '0; ECALL_READY = 1'b0; ECALL_DONE = 1'b0; ECALL_RET = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0; rs1_addr = 5'd2; rs2_addr = 5'd5;
      #1;
      check("reset_sp", rs1_val, 64'h8000);
      check("reset_x5", rs2_val, 64'h0);
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_instret", INSTRET, 64'd0);
      check("reset_valid", 64'(ECALL_VALID), 64'd0);

      // Table vectors: combinational reads (incl. bypass) and retire count
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         wb_enable = vecs[i].we; wb_dst_reg = vecs[i].dst; wb_dst_val = vecs[i].val;
         rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
         if (vecs[i].we) begin
            e.addr = vecs[i].dst;
            e.val  = (vecs[i].dst == 5'd0) ? '0 : vecs[i].val;
            sb_q.push_back(e);
         end
         #1;
         check($sformatf("vec%0d_rs1", i), rs1_val, vecs[i].exp1);
         check($sformatf("vec%0d_rs2", i), rs2_val, vecs[i].exp2);
         @(posedge clk); #1;
         check($sformatf("vec%0d_instret", i), INSTRET, vecs[i].exp_instret);
      end
      @(negedge clk);
      wb_enable = 1'b0;

      // Drain scoreboard: every committed write must be visible from the array
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         read_reg(e.addr, e.val, $sformatf("sb_x%0d", e.addr));
      end

      // Ecall with a stalled handler and an early DONE that must be ignored
      @(negedge clk);
      ecall_wb = 1'b1;
      @(posedge clk); #1;
      check("ec1_ready", 64'(ready), 64'd0);
      check("ec1_valid", 64'(ECALL_VALID), 64'd1);
      check("ec1_a0", ECALL_ARGS[63:0], 64'h1);
      check("ec1_a7", ECALL_ARGS[511:448], 64'd93);
      check("ec1_instret", INSTRET, 64'd6);
      args_a0_hold = ECALL_ARGS[63:0];
      args_a7_hold = ECALL_ARGS[511:448];
      @(negedge clk);
      ecall_wb = 1'b0;
      wb_enable = 1'b1; wb_dst_reg = 5'd12; wb_dst_val = 64'hBAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         ECALL_DONE = (c == 1); ECALL_RET = 64'h77;
         @(posedge clk); #1;
         check($sformatf("ec1_hold%0d_valid", c), 64'(ECALL_VALID), 64'd1);
         check($sformatf("ec1_hold%0d_a0", c), ECALL_ARGS[63:0], args_a0_hold);
         check($sformatf("ec1_hold%0d_a7", c), ECALL_ARGS[511:448], args_a7_hold);
      end
      @(negedge clk);
      ECALL_DONE = 1'b0; ECALL_READY = 1'b1;
      @(posedge clk); #1;
      check("ec1_accept_valid", 64'(ECALL_VALID), 64'd0);
      check("ec1_accept_ready", 64'(ready), 64'd0);
      @(negedge clk);
      ECALL_READY = 1'b0; ECALL_DONE = 1'b1; ECALL_RET = 64'h2A; rs1_addr = 5'd10;
      #1;
      check("ec1_ret_bypass", rs1_val, 64'h2A);
      @(posedge clk); #1;
      check("ec1_done_ready", 64'(ready), 64'd1);
      check("ec1_instret_after", INSTRET, 64'd6);
      @(negedge clk);
      ECALL_DONE = 1'b0; wb_enable = 1'b0;
      #1;
      check("ec1_x10", rs1_val, 64'h2A);
      read_reg(5'd12, 64'h0, "ec_ignored_wb_x12");

      // Ecall with a simultaneous write to a0: write dropped, a0 = previous RET
      @(negedge clk);
      ecall_wb = 1'b1; wb_enable = 1'b1; wb_dst_reg = 5'd10; wb_dst_val = 64'h99;
      @(posedge clk); #1;
      check("ec2_a0", ECALL_ARGS[63:0], 64'h2A);
      check("ec2_instret", INSTRET, 64'd7);
      @(negedge clk);
      ecall_wb = 1'b0; wb_enable = 1'b0; rs1_addr = 5'd10;
      #1;
      check("ec2_x10_kept", rs1_val, 64'h2A);
      ECALL_READY = 1'b1;
      @(posedge clk); #1;
      check("ec2_wait_valid", 64'(ECALL_VALID), 64'd0);

      // Reset while waiting for DONE, then a late DONE must not write a0
      @(negedge clk);
      ECALL_READY = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_valid", 64'(ECALL_VALID), 64'd0);
      check("rst_instret", INSTRET, 64'd0);
      check("rst_args", ECALL_ARGS[63:0], 64'd0);
      @(negedge clk);
      reset = 1'b0; ECALL_DONE = 1'b1; ECALL_RET = 64'h55;
      @(posedge clk); #1;
      check("rst_done_ready", 64'(ready), 64'd1);
      check("rst_done_valid", 64'(ECALL_VALID), 64'd0);
      @(negedge clk);
      ECALL_DONE = 1'b0;
      read_reg(5'd10, 64'h0, "rst_x10");
      read_reg(5'd2,  64'h8000, "rst_x2");
      read_reg(5'd7,  64'h0, "rst_x7");
      read_reg(5'd17, 64'h0, "rst_x17");
      check("rst_instret_final", INSTRET, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
